instr_mem_loadable: RTL

//  Parametrised successor of the fixed-program instruction memory. Holds the program in a

---
 rtl/cpu_pkg.sv | 19 +
 rtl/imem_ram_1r1w.sv | 40 ++++
 rtl/instr_mem_loadable.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default fetch widths and the loadable
// instruction-memory controller state encoding.
package cpu_pkg;

  localparam int unsigned INSTR_WIDTH_DEF = 19;
  localparam int unsigned ADDR_WIDTH_DEF  = 12;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } imem_state_t;

  // Index width for a memory of the given depth (at least one bit)
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// Single-clock 1R1W RAM: synchronous write, registered read.
// The read register can be loaded with FILL instead of array contents.
module imem_ram_1r1w
  import cpu_pkg::*;
#(
  parameter int unsigned       WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned       DEPTH = 4096,
  parameter logic [WIDTH-1:0]  FILL  = '0,
  parameter int unsigned       IW    = idx_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rfill,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are never reset
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value when no read is issued
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= FILL;
    end else if (re) begin
      rdata <= rfill ? FILL : mem[raddr];
    end
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Runtime-loadable instruction memory: streaming loader, bulk clear and
// one-cycle registered fetch, arbitrated by a RUN/LOAD/CLEAR state machine.
module instr_mem_loadable
  import cpu_pkg::*;
#(
  parameter int unsigned                INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int unsigned                ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int unsigned                DEPTH       = 4096,
  parameter logic [INSTR_WIDTH-1:0]     FILL_WORD   = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear_start,
  input  logic                   load_start,
  input  logic [ADDR_WIDTH-1:0]  load_base,
  input  logic                   load_valid,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  output logic                   load_done,
  output logic                   load_overflow,
  output logic [ADDR_WIDTH:0]    load_count,
  output logic                   busy,
  input  logic                   fetch_req,
  input  logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic                   fetch_valid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   fetch_error
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;
  localparam int unsigned IDX_W = idx_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(DEPTH);

  imem_state_t            state, state_nxt;
  logic [PTR_W-1:0]       ptr, ptr_nxt;
  logic [PTR_W-1:0]       count_nxt;
  logic                   overflow_nxt;
  logic                   done_nxt;
  logic                   ram_we;
  logic [INSTR_WIDTH-1:0] ram_wdata;
  logic                   fetch_acc;
  logic                   fetch_oob;
  logic                   base_oob;
  logic                   at_end;

  // Next-state, pointer, flag and RAM-port decode
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    count_nxt    = load_count;
    overflow_nxt = load_overflow;
    done_nxt     = 1'b0;
    ram_we       = 1'b0;
    ram_wdata    = load_data;
    fetch_acc    = 1'b0;
    fetch_oob    = {1'b0, fetch_addr} >= DEPTH_P;
    base_oob     = {1'b0, load_base} >= DEPTH_P;
    at_end       = (ptr == LAST_ADDR);

    case (state)
      RUN: begin
        fetch_acc = fetch_req;
        if (clear_start) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else if (load_start) begin
          count_nxt = '0;
          if (base_oob) begin
            // Nothing can be written: report overflow and finish at once
            overflow_nxt = 1'b1;
            done_nxt     = 1'b1;
          end else begin
            state_nxt    = LOAD;
            ptr_nxt      = {1'b0, load_base};
            overflow_nxt = 1'b0;
          end
        end
      end

      LOAD: begin
        if (load_valid) begin
          ram_we    = 1'b1;
          ptr_nxt   = ptr + PTR_W'(1);
          count_nxt = load_count + PTR_W'(1);
          if (load_last || at_end) begin
            state_nxt    = RUN;
            done_nxt     = 1'b1;
            overflow_nxt = at_end && !load_last;
          end
        end
      end

      CLEAR: begin
        ram_we    = 1'b1;
        ram_wdata = FILL_WORD;
        ptr_nxt   = ptr + PTR_W'(1);
        if (at_end) begin
          state_nxt = RUN;
          done_nxt  = 1'b1;
        end
      end

      default: state_nxt = RUN;
    endcase

    // An abort must not complete the beat presented in the same cycle
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      ptr           <= '0;
      load_count    <= '0;
      load_overflow <= 1'b0;
      load_done     <= 1'b0;
      load_ready    <= 1'b0;
      busy          <= 1'b0;
      fetch_valid   <= 1'b0;
      fetch_error   <= 1'b0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      load_count    <= count_nxt;
      load_overflow <= overflow_nxt;
      load_done     <= done_nxt;
      load_ready    <= (state_nxt == LOAD);
      busy          <= (state_nxt != RUN);
      fetch_valid   <= fetch_acc;
      fetch_error   <= fetch_acc && fetch_oob;
    end
  end

  imem_ram_1r1w #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (DEPTH),
    .FILL  (FILL_WORD),
    .IW    (IDX_W)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (ram_we),
    .waddr (IDX_W'(ptr)),
    .wdata (ram_wdata),
    .re    (fetch_acc),
    .rfill (fetch_oob),
    .raddr (IDX_W'(fetch_addr)),
    .rdata (instruction)
  );

endmodule
